raccoon_target: RTL and testbench
=================================

RACCOON_TARGET -- requirements
Module: raccoon_target

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000, address window base.
REQ-002 Parameter ADDR_MASK, default 32'hF000_0000, address bits compared for window match.
REQ-003 CLK  input  1  sole clock; all state changes on rising edge.
REQ-004 RST  input  1  reset, synchronous and active-high.
REQ-005 RaccIn  input  79  ring bus slot in, fed by upstream raccoon_delay output.
REQ-006 RaccOut  output  79  ring bus slot out, registered.
REQ-007 MemReq  output  1  local access request, held until acknowledged.
REQ-008 MemWr  output  1  1 = write, 0 = read; valid while MemReq.
REQ-009 MemAddr  output  32  local access address; valid while MemReq.
REQ-010 MemMask  output  4  byte enables; valid while MemReq.
REQ-011 MemWData  output  32  write data; valid while MemReq.
REQ-012 MemRData  input  32  read data, sampled in the MemAck cycle.
REQ-013 MemAck  input  1  access completion, single-cycle pulse.

Function
REQ-014 Slot layout: [78] VALID, [77] RESP, [76] WR, [75:72] MASK, [71:64] TAG, [63:32] ADDR, [31:0] DATA.
REQ-015 Match: VALID=1, RESP=0, (ADDR & ADDR_MASK) == (BASE_ADDR & ADDR_MASK).
REQ-016 States: IDLE, ACCESS, RESP; 2-bit encoding, no other reachable states.
REQ-017 Pass-through: every slot not consumed appears unchanged on RaccOut exactly 1 cycle later.
REQ-018 IDLE + match: capture slot fields, drive RaccOut to all-zero next cycle (slot emptied), go to ACCESS.
REQ-019 IDLE + no match: pass through, stay IDLE.
REQ-020 ACCESS: MemReq=1 from the first ACCESS cycle, with MemWr/MemAddr/MemMask/MemWData = captured WR/ADDR/MASK/DATA, all stable.
REQ-021 ACCESS + MemAck=1: latch MemRData if WR=0, MemReq=0 next cycle, go to RESP; MemAck with MemReq=0 ignored.
REQ-022 ACCESS/RESP: all incoming slots, including matching requests, pass through unchanged (requester retries on next ring lap).
REQ-023 RESP + RaccIn VALID=0: RaccOut next cycle = {1, 1, WR, MASK, TAG, ADDR, DATA'}, go to IDLE.
REQ-024 DATA' = latched MemRData for reads, captured write data for writes.
REQ-025 RESP + RaccIn VALID=1: pass through, remain in RESP; no time limit.
REQ-026 Response insertion and new-request capture never share a cycle; IDLE entered from RESP considers the next slot only.
REQ-027 Incoming RESP=1 slots are never consumed, even inside the window.
REQ-028 Min request-to-response latency: capture edge + 1 cycle MemReq + ack + 1 cycle insert = 3 cycles with same-cycle ack and empty slots.

Reset
REQ-029 RST=1 at an edge: RaccOut=0, MemReq=0, MemWr=0, MemAddr=0, MemMask=0, MemWData=0, state IDLE, captured fields and latched data cleared.
REQ-030 Reset mid-ACCESS or mid-RESP drops the pending transaction; no response is emitted; MemAck arriving after reset is ignored.
REQ-031 RST has priority over all other inputs in the same cycle.

Verification (BASE_ADDR=32'h1000_0000, ADDR_MASK=32'hF000_0000)
REQ-032 Read 32'h1000_0010 tag 8'h5A, MemAck 2 cycles after MemReq with MemRData 32'hDEAD_BEEF, empty slots -> MemReq high exactly 3 cycles, RaccOut slot VALID=1 RESP=1 TAG=8'h5A DATA=32'hDEAD_BEEF, the consumed slot emitted as all-zero.
REQ-033 Write to 32'h2000_0000 -> passes through unchanged 1 cycle later, MemReq stays 0.
REQ-034 Write 32'h1000_0004 data 32'h1234_5678 mask 4'h3, then continuous valid traffic for 5 cycles after ack -> traffic passed unchanged, response {WR=1, DATA=32'h1234_5678} inserted in the first empty slot.
REQ-035 Second matching request arrives during ACCESS -> passed through unchanged; only one MemReq transaction.
REQ-036 RST asserted in ACCESS, then MemAck pulse -> all outputs zero, no response slot within 20 cycles.
REQ-037 Incoming RESP=1 slot addressed to 32'h1000_0000 -> passed through unchanged, MemReq stays 0.

Source files
------------

// File: rtl/raccoon_target.sv
// Ring-bus target: consumes requests in its address window, runs one local
// memory access at a time and reinserts the response into an empty slot.
// Ports:
//   CLK, RST         clock, synchronous active-high reset
//   RaccIn, RaccOut  79-bit ring slot in / registered slot out
//   MemReq, MemWr    local access request (held until MemAck), write flag
//   MemAddr, MemMask address and byte enables of the held access
//   MemWData         write data of the held access
//   MemRData, MemAck read data and single-cycle completion pulse
module raccoon_target #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] ADDR_MASK = 32'hF000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [78:0] RaccIn,
  output logic [78:0] RaccOut,
  output logic        MemReq,
  output logic        MemWr,
  output logic [31:0] MemAddr,
  output logic [3:0]  MemMask,
  output logic [31:0] MemWData,
  input  logic [31:0] MemRData,
  input  logic        MemAck
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  state_e      state_q;
  logic [78:0] out_q;
  logic        req_q;
  logic        wr_q;
  logic [3:0]  mask_q;
  logic [7:0]  tag_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;

  logic        in_valid;
  logic        in_resp;
  logic [31:0] in_addr;
  logic        in_match;

  assign in_valid = RaccIn[78];
  assign in_resp  = RaccIn[77];
  assign in_addr  = RaccIn[63:32];
  assign in_match = in_valid && !in_resp &&
    ((in_addr & ADDR_MASK) == (BASE_ADDR & ADDR_MASK));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      out_q   <= '0;
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
      mask_q  <= '0;
      tag_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_match) begin
            // Consume the slot: it leaves as an empty slot.
            wr_q    <= RaccIn[76];
            mask_q  <= RaccIn[75:72];
            tag_q   <= RaccIn[71:64];
            addr_q  <= RaccIn[63:32];
            data_q  <= RaccIn[31:0];
            out_q   <= '0;
            req_q   <= 1'b1;
            state_q <= S_ACCESS;
          end else begin
            out_q <= RaccIn;
          end
        end
        S_ACCESS: begin
          out_q <= RaccIn;
          if (MemAck && req_q) begin
            // Read data replaces the request data in the response.
            if (!wr_q) data_q <= MemRData;
            req_q   <= 1'b0;
            state_q <= S_RESP;
          end
        end
        S_RESP: begin
          if (!in_valid) begin
            out_q   <= {1'b1, 1'b1, wr_q, mask_q,
                        tag_q, addr_q, data_q};
            state_q <= S_IDLE;
          end else begin
            out_q <= RaccIn;
          end
        end
        default: begin
          out_q   <= '0;
          req_q   <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign RaccOut  = out_q;
  assign MemReq   = req_q;
  assign MemWr    = wr_q;
  assign MemAddr  = addr_q;
  assign MemMask  = mask_q;
  assign MemWData = data_q;

endmodule

// File: tb/tb_raccoon_target.sv
// Testbench for raccoon_target: directed scenarios with literal expectations
// followed by random ring traffic checked against a transaction-level model.
module tb_raccoon_target;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [31:0] AMSK = 32'hF000_0000;

  logic        CLK = 1'b0;
  logic        RST;
  logic [78:0] RaccIn;
  logic [78:0] RaccOut;
  logic        MemReq;
  logic        MemWr;
  logic [31:0] MemAddr;
  logic [3:0]  MemMask;
  logic [31:0] MemWData;
  logic [31:0] MemRData;
  logic        MemAck;

  raccoon_target #(
    .BASE_ADDR(BASE),
    .ADDR_MASK(AMSK)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .RaccIn  (RaccIn),
    .RaccOut (RaccOut),
    .MemReq  (MemReq),
    .MemWr   (MemWr),
    .MemAddr (MemAddr),
    .MemMask (MemMask),
    .MemWData(MemWData),
    .MemRData(MemRData),
    .MemAck  (MemAck)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
  int req_cycles;
  int resp_seen;

  // Transaction-level reference: at most one owned request; it is either
  // waiting for memory or waiting for an empty slot to return in.
  typedef struct {
    bit          owned;
    bit          mem_done;
    bit          wr;
    logic [3:0]  mask;
    logic [7:0]  tag;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t        txn;
  logic [78:0] exp_out;

  function automatic logic [78:0] mk(
    input bit v, input bit r, input bit w, input logic [3:0] m,
    input logic [7:0] t, input logic [31:0] a, input logic [31:0] d);
    return {v, r, w, m, t, a, d};
  endfunction

  function automatic bit hits(input logic [78:0] s);
    return s[78] && !s[77] && ((s[63:32] & AMSK) == (BASE & AMSK));
  endfunction

  task automatic chk(input string nm, input logic [78:0] act,
                     input logic [78:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(posedge CLK) begin
    if (RST) begin
      txn = '{default: '0};
      exp_out = '0;
    end else if (!txn.owned) begin
      if (hits(RaccIn)) begin
        txn.owned    = 1'b1;
        txn.mem_done = 1'b0;
        txn.wr   = RaccIn[76];
        txn.mask = RaccIn[75:72];
        txn.tag  = RaccIn[71:64];
        txn.addr = RaccIn[63:32];
        txn.data = RaccIn[31:0];
        exp_out  = '0;
      end else begin
        exp_out = RaccIn;
      end
    end else if (!txn.mem_done) begin
      exp_out = RaccIn;
      if (MemAck) begin
        txn.mem_done = 1'b1;
        if (!txn.wr) txn.data = MemRData;
      end
    end else if (!RaccIn[78]) begin
      exp_out = mk(1, 1, txn.wr, txn.mask, txn.tag, txn.addr, txn.data);
      txn.owned = 1'b0;
    end else begin
      exp_out = RaccIn;
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("ring_out", RaccOut, exp_out);
      chk("mem_req", {78'd0, MemReq},
          {78'd0, txn.owned && !txn.mem_done});
      if (txn.owned && !txn.mem_done)
        chk("mem_cmd", {10'd0, MemWr, MemAddr, MemMask, MemWData},
            {10'd0, txn.wr, txn.addr, txn.mask, txn.data});
    end
  end

  task automatic step(input logic [78:0] s, input logic ack,
                      input logic [31:0] rd, input logic rst);
    RaccIn   = s;
    MemAck   = ack;
    MemRData = rd;
    RST      = rst;
    @(posedge CLK);
    @(negedge CLK);
    if (MemReq === 1'b1) req_cycles++;
    if (RaccOut[78] === 1'b1 && RaccOut[77] === 1'b1) resp_seen++;
  endtask

  function automatic logic [78:0] rnd_slot();
    logic [78:0] s;
    int r;
    s = {$urandom, $urandom, $urandom};
    r = $urandom_range(0, 9);
    if (r < 4) begin
      s[78] = 1'b0;
    end else begin
      s[78] = 1'b1;
      s[77] = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 1) == 1) s[63:60] = 4'h1;
    end
    return s;
  endfunction

  logic [78:0] s1;
  logic [78:0] s2;
  logic [78:0] trf [5];
  logic        ack;

  initial begin
    RST = 1'b1;
    RaccIn = '0;
    MemAck = 1'b0;
    MemRData = '0;
    step('0, 0, 0, 1);
    chk_en = 1'b1;
    step('0, 0, 0, 1);
    chk("rst_out", RaccOut, '0);
    chk("rst_mem", {10'd0, MemReq, MemWr, MemAddr, MemMask, MemWData},
        '0);

    // Read with ack in the third MemReq cycle.
    s1 = mk(1, 0, 0, 4'hF, 8'h5A, 32'h1000_0010, 32'h0);
    req_cycles = 0;
    step(s1, 0, 0, 0);
    chk("rd_consumed", RaccOut, '0);
    step('0, 0, 0, 0);
    step('0, 0, 0, 0);
    step('0, 1, 32'hDEAD_BEEF, 0);
    step('0, 0, 0, 0);
    chk("rd_resp", RaccOut,
        mk(1, 1, 0, 4'hF, 8'h5A, 32'h1000_0010, 32'hDEAD_BEEF));
    chk("rd_req_len", req_cycles, 3);

    // Out-of-window write passes through.
    s1 = mk(1, 0, 1, 4'hF, 8'h01, 32'h2000_0000, 32'hAAAA_5555);
    req_cycles = 0;
    step(s1, 0, 0, 0);
    chk("miss_pass", RaccOut, s1);
    step('0, 0, 0, 0);
    chk("miss_noreq", req_cycles, 0);

    // Minimum latency: same-cycle ack, empty ring.
    s1 = mk(1, 0, 1, 4'h1, 8'h22, 32'h1000_0008, 32'h0BAD_F00D);
    step(s1, 0, 0, 0);
    step('0, 1, 32'hFFFF_FFFF, 0);
    step('0, 0, 0, 0);
    chk("lat3_resp", RaccOut,
        mk(1, 1, 1, 4'h1, 8'h22, 32'h1000_0008, 32'h0BAD_F00D));

    // Write, then 5 cycles of full ring before the response fits.
    s1 = mk(1, 0, 1, 4'h3, 8'h11, 32'h1000_0004, 32'h1234_5678);
    step(s1, 0, 0, 0);
    chk("wr_consumed", RaccOut, '0);
    step('0, 1, 32'h0, 0);
    for (int i = 0; i < 5; i++) begin
      trf[i] = mk(1, 0, 0, 4'hF, 8'(i), 32'h1000_0100 + 32'(i),
                  32'(i * 7));
      step(trf[i], 0, 0, 0);
      chk("wr_traffic", RaccOut, trf[i]);
    end
    step('0, 0, 0, 0);
    chk("wr_resp", RaccOut,
        mk(1, 1, 1, 4'h3, 8'h11, 32'h1000_0004, 32'h1234_5678));

    // Second matching request during ACCESS is not consumed.
    s1 = mk(1, 0, 0, 4'hF, 8'h33, 32'h1000_0020, 32'h0);
    s2 = mk(1, 0, 0, 4'hF, 8'h44, 32'h1000_0024, 32'h0);
    step(s1, 0, 0, 0);
    step(s2, 0, 0, 0);
    chk("dup_pass", RaccOut, s2);
    step('0, 1, 32'h7777_0001, 0);
    step('0, 0, 0, 0);
    chk("dup_resp", RaccOut,
        mk(1, 1, 0, 4'hF, 8'h33, 32'h1000_0020, 32'h7777_0001));
    req_cycles = 0;
    for (int i = 0; i < 4; i++) step('0, 0, 0, 0);
    chk("dup_one_txn", req_cycles, 0);

    // Reset mid-access, then a stale ack.
    s1 = mk(1, 0, 0, 4'hF, 8'h66, 32'h1000_0030, 32'h0);
    step(s1, 0, 0, 0);
    step('0, 0, 0, 1);
    chk("rst_acc_mem",
        {10'd0, MemReq, MemWr, MemAddr, MemMask, MemWData}, '0);
    chk("rst_acc_out", RaccOut, '0);
    req_cycles = 0;
    resp_seen  = 0;
    step('0, 1, 32'h1111_2222, 0);
    for (int i = 0; i < 20; i++) step('0, 0, 0, 0);
    chk("rst_no_resp", resp_seen, 0);
    chk("rst_no_req", req_cycles, 0);

    // Response slot inside the window is never consumed.
    s1 = mk(1, 1, 0, 4'hF, 8'h77, 32'h1000_0000, 32'h5555_AAAA);
    req_cycles = 0;
    step(s1, 0, 0, 0);
    chk("resp_pass", RaccOut, s1);
    step('0, 0, 0, 0);
    chk("resp_noreq", req_cycles, 0);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      if (MemReq) ack = ($urandom_range(0, 2) == 0);
      else        ack = ($urandom_range(0, 9) == 0);
      step(rnd_slot(), ack, $urandom, $urandom_range(0, 299) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
